// File: rtl/nor_flash_pkg.sv
// Shared definitions for the parallel NOR-flash command set: opcodes, status
// register bit positions and the responder state encoding.
package nor_flash_pkg;

   localparam logic [7:0] OP_READ_ARRAY     = 8'hFF;
   localparam logic [7:0] OP_READ_STATUS    = 8'h70;
   localparam logic [7:0] OP_CLEAR_STATUS   = 8'h50;
   localparam logic [7:0] OP_PROG_SETUP     = 8'h40;
   localparam logic [7:0] OP_PROG_SETUP_ALT = 8'h10;
   localparam logic [7:0] OP_ERASE_SETUP    = 8'h20;
   localparam logic [7:0] OP_ERASE_CONFIRM  = 8'hD0;

   localparam int SR_READY     = 7;
   localparam int SR_ERASE_ERR = 5;
   localparam int SR_PROG_ERR  = 4;
   localparam int SR_PROTECT   = 1;

   localparam logic [2:0] ST_READ_ARRAY  = 3'd0;
   localparam logic [2:0] ST_READ_STATUS = 3'd1;
   localparam logic [2:0] ST_PROG_SETUP  = 3'd2;
   localparam logic [2:0] ST_ERASE_SETUP = 3'd3;
   localparam logic [2:0] ST_BUSY_PROG   = 3'd4;
   localparam logic [2:0] ST_BUSY_ERASE  = 3'd5;

   function automatic logic [7:0] sr_pack(input logic ready, input logic erase_err,
                                          input logic prog_err, input logic protect);
      logic [7:0] v;
      v               = 8'h00;
      v[SR_READY]     = ready;
      v[SR_ERASE_ERR] = erase_err;
      v[SR_PROG_ERR]  = prog_err;
      v[SR_PROTECT]   = protect;
      return v;
   endfunction

endpackage

// File: rtl/nor_flash_strobe_sync.sv
// Synchronises every NF_* input through SYNC_STAGES flops as one bus and
// produces a single-clock pulse on the synced WE rising edge.
module nor_flash_strobe_sync #(
   parameter int ADDR_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ce_n,
   input  logic              i_oe_n,
   input  logic              i_we_n,
   input  logic              i_rp_n,
   input  logic              i_wp_n,
   input  logic [ADDR_W-1:0] i_a,
   input  logic [7:0]        i_d,
   output logic              o_ce_n,
   output logic              o_oe_n,
   output logic              o_rp_n,
   output logic              o_wp_n,
   output logic [ADDR_W-1:0] o_a,
   output logic [7:0]        o_d,
   output logic              o_we_rise
);

   localparam int W = 5 + ADDR_W + 8;
   // Strobes idle high so a reset never fabricates a write edge.
   localparam logic [W-1:0] RST_VAL = {5'b11111, {(ADDR_W + 8){1'b0}}};

   logic [SYNC_STAGES-1:0][W-1:0] r_pipe;
   logic                          r_we_prev;
   logic [W-1:0]                  w_in;
   logic [W-1:0]                  w_out;
   logic                          w_we_n;

   assign w_in  = {i_ce_n, i_oe_n, i_we_n, i_rp_n, i_wp_n, i_a, i_d};
   assign w_out = r_pipe[SYNC_STAGES-1];
   assign {o_ce_n, o_oe_n, w_we_n, o_rp_n, o_wp_n, o_a, o_d} = w_out;
   assign o_we_rise = w_we_n & ~r_we_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pipe    <= {SYNC_STAGES{RST_VAL}};
         r_we_prev <= 1'b1;
      end else begin
         r_pipe[0] <= w_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_pipe[s] <= r_pipe[s-1];
         end
         r_we_prev <= w_we_n;
      end
   end

endmodule

// File: rtl/nor_flash_responder.sv
// Device side of the parallel NOR-flash bus: command decoder, byte array,
// timed program/erase busy phases and array/status read-back.
module nor_flash_responder
   import nor_flash_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int PROG_CYCLES = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK_50MHZ,
   input  logic              RST,
   input  logic [ADDR_W-1:0] NF_A,
   input  logic [7:0]        NF_D_IN,
   output logic [7:0]        NF_D_OUT,
   output logic              NF_D_OE,
   input  logic              NF_CE,
   input  logic              NF_OE,
   input  logic              NF_WE,
   input  logic              NF_RP,
   input  logic              NF_WP,
   input  logic              NF_BYTE,
   output logic              NF_STS,
   output logic [2:0]        o_dbg_state
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = (ADDR_W > 16) ? ADDR_W : 16;

   logic              w_ce_n, w_oe_n, w_rp_n, w_wp_n, w_we_rise;
   logic [ADDR_W-1:0] w_a;
   logic [7:0]        w_d;
   logic              w_unused;

   nor_flash_strobe_sync #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk(CLK_50MHZ), .i_rst(RST),
      .i_ce_n(NF_CE), .i_oe_n(NF_OE), .i_we_n(NF_WE), .i_rp_n(NF_RP), .i_wp_n(NF_WP),
      .i_a(NF_A), .i_d(NF_D_IN),
      .o_ce_n(w_ce_n), .o_oe_n(w_oe_n), .o_rp_n(w_rp_n), .o_wp_n(w_wp_n),
      .o_a(w_a), .o_d(w_d), .o_we_rise(w_we_rise)
   );

   assign w_unused = NF_BYTE;

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_prog_a;
   logic [7:0]        r_prog_d;
   logic              r_err_erase, r_err_prog, r_err_prot;
   logic              r_d_oe;
   logic [7:0]        r_d_out;

   // Array is stored inverted so the all-zero power-up state reads as erased 0xFF.
   logic [7:0]        r_mem_n [0:DEPTH-1];

   logic              w_busy, w_read, w_write, w_prog_last, w_erase_last, w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [7:0]        w_mem_wdata_n;
   logic [7:0]        w_sr;

   assign w_busy       = (r_state == ST_BUSY_PROG) || (r_state == ST_BUSY_ERASE);
   assign w_sr         = sr_pack(~w_busy, r_err_erase, r_err_prog, r_err_prot);
   assign w_read       = ~w_ce_n & ~w_oe_n;
   assign w_write      = w_we_rise & ~w_ce_n & w_oe_n & ~w_busy;
   assign w_prog_last  = (r_state == ST_BUSY_PROG) && (r_cnt == CNT_W'(PROG_CYCLES - 1));
   assign w_erase_last = (r_state == ST_BUSY_ERASE) && (r_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});

   assign w_mem_we      = w_rp_n & (w_prog_last | (r_state == ST_BUSY_ERASE));
   assign w_mem_addr    = (r_state == ST_BUSY_ERASE) ? r_cnt[ADDR_W-1:0] : r_prog_a;
   assign w_mem_wdata_n = (r_state == ST_BUSY_ERASE) ? 8'h00 : (r_mem_n[r_prog_a] | ~r_prog_d);

   always_ff @(posedge CLK_50MHZ) begin
      if (w_mem_we) begin
         r_mem_n[w_mem_addr] <= w_mem_wdata_n;
      end
   end

   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         r_state     <= ST_READ_ARRAY;
         r_cnt       <= '0;
         r_prog_a    <= '0;
         r_prog_d    <= 8'h00;
         r_err_erase <= 1'b0;
         r_err_prog  <= 1'b0;
         r_err_prot  <= 1'b0;
         r_d_oe      <= 1'b0;
         r_d_out     <= 8'h00;
      end else if (!w_rp_n) begin
         r_state     <= ST_READ_ARRAY;
         r_cnt       <= '0;
         r_prog_a    <= '0;
         r_prog_d    <= 8'h00;
         r_err_erase <= 1'b0;
         r_err_prog  <= 1'b0;
         r_err_prot  <= 1'b0;
         r_d_oe      <= 1'b0;
         r_d_out     <= 8'h00;
      end else begin
         r_d_oe  <= w_read;
         r_d_out <= !w_read ? 8'h00 :
                    (r_state == ST_READ_ARRAY) ? ~r_mem_n[w_a] : w_sr;
         case (r_state)
            ST_READ_ARRAY, ST_READ_STATUS: begin
               if (w_write) begin
                  case (w_d)
                     OP_READ_ARRAY:   r_state <= ST_READ_ARRAY;
                     OP_READ_STATUS:  r_state <= ST_READ_STATUS;
                     OP_CLEAR_STATUS: begin
                        r_err_erase <= 1'b0;
                        r_err_prog  <= 1'b0;
                        r_err_prot  <= 1'b0;
                     end
                     OP_PROG_SETUP, OP_PROG_SETUP_ALT: r_state <= ST_PROG_SETUP;
                     OP_ERASE_SETUP:  r_state <= ST_ERASE_SETUP;
                     default: ;
                  endcase
               end
            end
            ST_PROG_SETUP: begin
               if (w_write) begin
                  if (!w_wp_n) begin
                     r_err_prog <= 1'b1;
                     r_err_prot <= 1'b1;
                     r_state    <= ST_READ_STATUS;
                  end else begin
                     r_prog_a <= w_a;
                     r_prog_d <= w_d;
                     r_cnt    <= '0;
                     r_state  <= ST_BUSY_PROG;
                  end
               end
            end
            ST_ERASE_SETUP: begin
               if (w_write) begin
                  if (w_d != OP_ERASE_CONFIRM) begin
                     r_err_erase <= 1'b1;
                     r_err_prog  <= 1'b1;
                     r_state     <= ST_READ_STATUS;
                  end else if (!w_wp_n) begin
                     r_err_erase <= 1'b1;
                     r_err_prot  <= 1'b1;
                     r_state     <= ST_READ_STATUS;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= ST_BUSY_ERASE;
                  end
               end
            end
            ST_BUSY_PROG: begin
               if (w_prog_last) r_state <= ST_READ_STATUS;
               else             r_cnt   <= r_cnt + CNT_W'(1);
            end
            ST_BUSY_ERASE: begin
               if (w_erase_last) r_state <= ST_READ_STATUS;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_state <= ST_READ_ARRAY;
         endcase
      end
   end

   assign NF_STS      = ~w_busy;
   assign NF_D_OE     = r_d_oe;
   assign NF_D_OUT    = r_d_out;
   assign o_dbg_state = r_state;

endmodule
